// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: drives the 2-bit mode select of an up/down counter so that the
// counter travels from its current value to a latched target, then parks on hold.
// Supports pause, abort, a saturating step count and a step-limit error exit.
module count_seq_ctrl #(
  parameter int WIDTH     = 4,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [WIDTH-1:0]  target,
  input  logic              pause,
  input  logic              abort,
  input  logic [WIDTH-1:0]  count_in,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] steps
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0]        SEL_HOLD  = 2'b00;
  localparam logic [1:0]        SEL_UP    = 2'b01;
  localparam logic [1:0]        SEL_DN    = 2'b10;
  localparam logic [STEP_W-1:0] STEP_LIM  = STEP_W'(MAX_STEPS);

  // Step count never wraps; it sticks at all-ones.
  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    sat_inc = (v == {STEP_W{1'b1}}) ? v : v + STEP_W'(1);
  endfunction

  // Direction code for the counter; 11 is never produced.
  function automatic logic [1:0] dir_code(input logic d);
    dir_code = d ? SEL_DN : SEL_UP;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic               dir_q, dir_d;
  logic [1:0]         sel_d;
  logic               busy_d, done_d, err_d;
  logic [STEP_W-1:0]  steps_d;
  logic [WIDTH-1:0]   nxt;
  logic               moving;
  logic [STEP_W-1:0]  steps_adv;
  logic               accept;

  // Predict the counter value after this edge so the run stops exactly on target.
  always_comb begin
    moving    = (sel != SEL_HOLD);
    steps_adv = moving ? sat_inc(steps) : steps;
    unique case (sel)
      SEL_UP:  nxt = count_in + WIDTH'(1);
      SEL_DN:  nxt = count_in - WIDTH'(1);
      default: nxt = count_in;
    endcase
  end

  // Next-state and registered-output decode; abort always beats start.
  always_comb begin
    state_d = state_q;
    sel_d   = SEL_HOLD;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err;
    steps_d = steps;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    accept  = start && !abort && ((state_q == S_IDLE) || (state_q == S_ERR));

    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (state_q == S_ERR && abort) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end else if (accept) begin
          tgt_d   = target;
          dir_d   = dir;
          steps_d = '0;
          err_d   = 1'b0;
          if (count_in == target) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            sel_d   = dir_code(dir);
          end
        end
      end
      S_RUN: begin
        steps_d = steps_adv;
        if (abort) begin
          state_d = S_IDLE;
        end else if (nxt == tgt_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (steps_adv == STEP_LIM) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          busy_d  = 1'b1;
          sel_d   = pause ? SEL_HOLD : dir_code(dir_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and all outputs are registered; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sel     <= SEL_HOLD;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      steps   <= '0;
      tgt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      steps   <= steps_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
    end
  end

endmodule
